ft_store_buffer: RTL

Fault-tolerant store buffer placed downstream of the result comparator, between the core's data-write path and the data memory port. It accepts store requests together with the comparator's agree/disagree verdict, discards and records any store whose redundant results disagree, and queues agreed stores in a small FIFO. It then drains them to memory over the req/gnt handshake that memory already exposes. It also provides error and occupancy status for the SoC testbench.

---
 rtl/ft_store_buffer_if.sv | 47 ++++
 rtl/ft_store_buffer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ft_store_buffer_if.sv
// ----------------------------------------------------------------------------
// ft_store_buffer_if
// Bundles the store-side handshake (core -> buffer) and the memory write
// handshake (buffer -> data memory) of the fault-tolerant store buffer.
//
// Signals:
//   wr_valid  core presents a store this cycle
//   wr_ready  buffer can accept a store this cycle
//   wr_addr   store byte address
//   wr_data   comparator-selected store data
//   wr_be     byte enables
//   match     comparator verdict, 1 = replicas agree
//   mem_req   write request to data memory
//   mem_gnt   memory grant, request consumed on req & gnt
//   mem_we    write enable, mirrors mem_req
//   mem_addr  head-entry address (0 while idle)
//   mem_wdata head-entry data (0 while idle)
//   mem_be    head-entry byte enables (0 while idle)
//
// Modports:
//   slave  - the store buffer's view
//   master - the surrounding core/memory environment's view
// ----------------------------------------------------------------------------
interface ft_store_buffer_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        match;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_be, match, mem_gnt,
        output wr_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output wr_valid, wr_addr, wr_data, wr_be, match, mem_gnt,
        input  wr_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/ft_store_buffer.sv
// ----------------------------------------------------------------------------
// ft_store_buffer
// Fault-tolerant store buffer sitting behind the result comparator. Stores
// whose redundant results agree are queued in a small FIFO and drained to
// data memory over a req/gnt handshake; stores whose results disagree are
// dropped, counted and their address recorded.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, 2..16)
//   CNT_W  width of the saturating error counter
//
// Ports:
//   clk_i       clock, all state updates on the rising edge
//   rst_i       synchronous active-high reset
//   bus         store and memory handshakes (ft_store_buffer_if.slave)
//   mismatch_o  one-cycle pulse after a store is rejected
//   err_cnt_o   saturating count of rejected stores
//   err_addr_o  address of the most recent rejected store
//   empty_o     FIFO empty and no memory request outstanding
// ----------------------------------------------------------------------------
module ft_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ft_store_buffer_if.slave   bus,
    output logic               mismatch_o,
    output logic [CNT_W-1:0]   err_cnt_o,
    output logic [31:0]        err_addr_o,
    output logic               empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   COUNT_ZERO = '0;
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] ERR_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ERR_MAX    = '1;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_e;

    state_e            state_q;
    logic              req_q;

    logic [31:0]       addr_mem_q [DEPTH];
    logic [31:0]       data_mem_q [DEPTH];
    logic [3:0]        be_mem_q   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic [PTR_W:0]    count_d;

    logic              mismatch_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [31:0]       err_addr_q;

    logic              wr_ready;
    logic              push;
    logic              reject;
    logic              pop;

    // Readiness depends only on the registered count, so a pop in the same
    // cycle never frees a slot for a push into a full buffer.
    assign wr_ready = (count_q != COUNT_FULL);
    assign push     = bus.wr_valid & wr_ready & bus.match;
    assign reject   = bus.wr_valid & wr_ready & ~bus.match;
    assign pop      = req_q & bus.mem_gnt;

    // Occupancy after this edge; a simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - COUNT_ONE;
        end
    end

    // Entry storage carries no reset: validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= bus.wr_addr;
            data_mem_q[wr_ptr_q] <= bus.wr_data;
            be_mem_q[wr_ptr_q]   <= bus.wr_be;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // Drain FSM: leaves IDLE one cycle after data lands in the FIFO and
    // stays in REQ for back-to-back commits until the FIFO runs dry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q != COUNT_ZERO) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (pop && (count_d == COUNT_ZERO)) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Rejected-store bookkeeping; the counter sticks at its maximum.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            mismatch_q <= reject;
            if (reject) begin
                err_addr_q <= bus.wr_addr;
                if (err_cnt_q != ERR_MAX) begin
                    err_cnt_q <= err_cnt_q + ERR_ONE;
                end
            end
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = req_q;
    assign bus.mem_addr  = req_q ? addr_mem_q[rd_ptr_q] : 32'h0;
    assign bus.mem_wdata = req_q ? data_mem_q[rd_ptr_q] : 32'h0;
    assign bus.mem_be    = req_q ? be_mem_q[rd_ptr_q]   : 4'h0;

    assign mismatch_o = mismatch_q;
    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;
    assign empty_o    = (count_q == COUNT_ZERO) && (state_q == ST_IDLE);

endmodule
